// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states, flag bit
// positions (matching the control unit) and the MDU opsel codes.
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_MUL = 2'd0,
        K_DIV = 2'd1,
        K_MOD = 2'd2
    } kind_t;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_NF = 2;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 0;

    localparam logic [4:0] MDU_OP_MUL = 5'd12;
    localparam logic [4:0] MDU_OP_DIV = 5'd13;
    localparam logic [4:0] MDU_OP_MOD = 5'd14;

    function automatic logic [3:0] pack_flags(input logic zf, input logic nf,
                                              input logic cf, input logic of);
        logic [3:0] f;
        f          = '0;
        f[FLAG_ZF] = zf;
        f[FLAG_NF] = nf;
        f[FLAG_CF] = cf;
        f[FLAG_OF] = of;
        return f;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iteration datapath: shift-add multiply and restoring divide run side by side,
// one step per `step`; next-step values are exposed so the final step can be registered.
module mdu_iter_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod_nxt,
    output logic [WIDTH-1:0]     quo_nxt,
    output logic [WIDTH-1:0]     rem_nxt,
    output logic                 mul_exhausted
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     trial;
    logic               ge;

    always_comb begin
        prod_nxt      = acc + (mplier[0] ? mcand : '0);
        // after this step no multiplier bits remain, so the product is final
        mul_exhausted = (mplier[WIDTH-1:1] == '0);
        trial         = {rem, quo[WIDTH-1]};
        ge            = (trial >= {1'b0, divisor});
        // remainder stays below divisor, so the W-bit difference never wraps
        rem_nxt       = ge ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
        quo_nxt       = {quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
        end else if (load) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            acc     <= '0;
            mplier  <= b;
            quo     <= a;
            rem     <= '0;
            divisor <= b;
        end else if (step) begin
            acc    <= prod_nxt;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            quo    <= quo_nxt;
            rem    <= rem_nxt;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV/MOD sequencer; holds ready low while an op iterates.
// Optional build macro MDU_EARLY_EXIT_EN lets MUL finish once the multiplier is exhausted.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int         WIDTH  = 16,
    parameter logic [4:0] OP_MUL = MDU_OP_MUL,
    parameter logic [4:0] OP_DIV = MDU_OP_DIV,
    parameter logic [4:0] OP_MOD = MDU_OP_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opsel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             ready,
    output logic             mdu_active,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       mdu_flags,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
`ifdef MDU_EARLY_EXIT_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    state_t             state;
    kind_t              kind;
    logic [CW-1:0]      count;
    logic               load;
    logic               step;
    logic               last;
    logic               div_req;
    logic               fin_hi;
    logic               mul_exhausted;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   fin_res;
    logic [WIDTH-1:0]   dz_res;

    assign mdu_active = (opsel == OP_MUL) || (opsel == OP_DIV) || (opsel == OP_MOD);
    assign ready      = (state == S_DONE) || ((state == S_IDLE) && !mdu_active);
    assign load       = (state == S_IDLE) && mdu_active;
    assign step       = (state == S_BUSY);

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .step          (step),
        .a             (src_a),
        .b             (src_b),
        .prod_nxt      (prod_nxt),
        .quo_nxt       (quo_nxt),
        .rem_nxt       (rem_nxt),
        .mul_exhausted (mul_exhausted)
    );

    always_comb begin
        div_req = (opsel == OP_DIV) || (opsel == OP_MOD);
        dz_res  = (opsel == OP_DIV) ? {WIDTH{1'b1}} : src_a;
        case (kind)
            K_MUL:   fin_res = prod_nxt[WIDTH-1:0];
            K_DIV:   fin_res = quo_nxt;
            default: fin_res = rem_nxt;
        endcase
        fin_hi = (kind == K_MUL) && (|prod_nxt[2*WIDTH-1:WIDTH]);
        last   = (count == CW'(WIDTH - 1)) || (EARLY && (kind == K_MUL) && mul_exhausted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            kind      <= K_MUL;
            count     <= '0;
            result    <= '0;
            mdu_flags <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mdu_active) begin
                        count <= '0;
                        kind  <= (opsel == OP_MUL) ? K_MUL : ((opsel == OP_DIV) ? K_DIV : K_MOD);
                        if (div_req && (src_b == '0)) begin
                            state     <= S_DONE;
                            div_zero  <= 1'b1;
                            result    <= dz_res;
                            mdu_flags <= pack_flags(dz_res == '0, dz_res[WIDTH-1], 1'b0, 1'b1);
                        end else begin
                            state    <= S_BUSY;
                            div_zero <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    count <= count + 1'b1;
                    if (last) begin
                        state     <= S_DONE;
                        result    <= fin_res;
                        mdu_flags <= pack_flags(fin_res == '0, fin_res[WIDTH-1], fin_hi, fin_hi);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: arithmetic reference model with a per-cycle
// compare process, directed literal cases and randomized MUL/DIV/MOD traffic.
module tb_mdu_sequencer;

    localparam int         W    = 16;
    localparam logic [4:0] MUL  = 5'd12;
    localparam logic [4:0] DIV  = 5'd13;
    localparam logic [4:0] MOD  = 5'd14;
    localparam logic [4:0] ADD  = 5'd0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    opsel = ADD;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic          ready;
    logic          mdu_active;
    logic [W-1:0]  result;
    logic [3:0]    mdu_flags;
    logic          div_zero;

    int checks = 0;
    int errors = 0;

    mdu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .opsel      (opsel),
        .src_a      (src_a),
        .src_b      (src_b),
        .ready      (ready),
        .mdu_active (mdu_active),
        .result     (result),
        .mdu_flags  (mdu_flags),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_mdu(input logic [4:0] o);
        return (o == MUL) || (o == DIV) || (o == MOD);
    endfunction

    // cycles from opsel presentation until ready
    function automatic int exp_lat(input logic [4:0] op, input logic [W-1:0] b);
        int n;
        if (op != MUL && b == 0) return 1;
`ifdef MDU_EARLY_EXIT_EN
        if (op == MUL) begin
            n = 1;
            for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
            return n + 1;
        end
`endif
        n = W + 1;
        return n;
    endfunction

    task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic [3:0] flags, output logic dz);
        logic [31:0] p;
        logic        cf;
        logic        of;
        cf = 1'b0;
        dz = 1'b0;
        if (op == MUL) begin
            p   = 32'(a) * 32'(b);
            res = p[15:0];
            cf  = (p[31:16] != 0);
        end else if (b == 0) begin
            dz  = 1'b1;
            res = (op == DIV) ? 16'hFFFF : a;
        end else begin
            res = (op == DIV) ? a / b : a % b;
        end
        of    = (op == MUL) ? cf : dz;
        flags = {res == 0, res[15], cf, of};
    endtask

    // per-cycle compare against the model
    int           pend = 0;
    logic [W-1:0] m_res;
    logic [3:0]   m_flags;
    logic         m_dz;

    always @(negedge clk) begin
        chk("mdu_active", 32'(mdu_active), 32'(is_mdu(opsel)));
        if (rst) begin
            pend = 0;
            chk("rst_result", 32'(result), 0);
            chk("rst_flags", 32'(mdu_flags), 0);
            chk("rst_div_zero", 32'(div_zero), 0);
            chk("rst_ready", 32'(ready), 32'(!is_mdu(opsel)));
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                chk("done_ready", 32'(ready), 1);
                chk("done_result", 32'(result), 32'(m_res));
                chk("done_flags", 32'(mdu_flags), 32'(m_flags));
                chk("done_div_zero", 32'(div_zero), 32'(m_dz));
            end else begin
                chk("busy_ready", 32'(ready), 0);
            end
        end else begin
            chk("idle_ready", 32'(ready), 32'(!is_mdu(opsel)));
            if (is_mdu(opsel)) begin
                model(opsel, src_a, src_b, m_res, m_flags, m_dz);
                pend = exp_lat(opsel, src_b);
            end
        end
    end

    // called just after a rising edge with the DUT in IDLE
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic scramble, input logic lit,
                          input logic [W-1:0] l_res, input logic [3:0] l_flags,
                          input logic l_dz, input int l_lat);
        int   c;
        logic got;
        opsel = op;
        src_a = a;
        src_b = b;
        got   = 1'b0;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (scramble) begin
                src_a = 16'($urandom);
                src_b = 16'($urandom);
                if ($urandom_range(0, 3) == 0) opsel = ADD;
            end
        end
        chk("ready_timeout", 32'(got), 1);
        if (lit) begin
            chk("lit_latency", 32'(c), 32'(l_lat));
            chk("lit_result", 32'(result), 32'(l_res));
            chk("lit_flags", 32'(mdu_flags), 32'(l_flags));
            chk("lit_div_zero", 32'(div_zero), 32'(l_dz));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        opsel = ADD;
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] ops [3];
        logic [4:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        ops[0] = MUL;
        ops[1] = DIV;
        ops[2] = MOD;

        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        run_op(MUL, 16'd300, 16'd200, 1'b0, 1'b1, 16'd60000, 4'b0100, 1'b0, W + 1);
        run_op(MUL, 16'h0100, 16'h0100, 1'b0, 1'b1, 16'h0000, 4'b1011, 1'b0, W + 1);
        run_op(DIV, 16'd1000, 16'd7, 1'b0, 1'b1, 16'd142, 4'b0000, 1'b0, W + 1);
        run_op(MOD, 16'd1000, 16'd7, 1'b0, 1'b1, 16'd6, 4'b0000, 1'b0, W + 1);
        run_op(DIV, 16'd55, 16'd0, 1'b0, 1'b1, 16'hFFFF, 4'b0101, 1'b1, 1);
        run_op(MOD, 16'd55, 16'd0, 1'b0, 1'b1, 16'd55, 4'b0001, 1'b1, 1);
        idle(5);

        // reset in the middle of a MUL (BUSY count 8, cycle 9)
        opsel = MUL;
        src_a = 16'd300;
        src_b = 16'd200;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        opsel = ADD;
        #1;
        chk("async_rst_result", 32'(result), 0);
        chk("async_rst_ready", 32'(ready), 1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_op(MUL, 16'd300, 16'd200, 1'b0, 1'b1, 16'd60000, 4'b0100, 1'b0, W + 1);
        idle(2);

`ifdef MDU_EARLY_EXIT_EN
        run_op(MUL, 16'd1234, 16'd3, 1'b0, 1'b1, 16'd3702, 4'b0000, 1'b0, 3);
`else
        run_op(MUL, 16'd1234, 16'd3, 1'b0, 1'b1, 16'd3702, 4'b0000, 1'b0, W + 1);
`endif
        idle(2);

        repeat (40) begin
            op = ops[$urandom_range(0, 2)];
            a  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 16'($urandom_range(0, 3));
                default: b = 16'($urandom);
            endcase
            run_op(op, a, b, 1'b1, 1'b0, '0, '0, 1'b0, 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
